// File: rtl/increment_counter.sv
// Loadable up-counter from start_val to stop_val; next count comes from a ripple
// chain of full-adder cells adding 1, with a small IDLE/COUNT/DONE sequencer.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module increment_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] stop_val,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] stop_reg;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH:0]   carry;

    // +1 ripple chain: b inputs tied low, carry-in of bit 0 tied high.
    // The MSB carry-out only fires on all-ones -> 0, so it doubles as the wrap flag.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (count[i]),
            .b    (1'b0),
            .cin  (carry[i]),
            .s    (count_inc[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            stop_reg <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            done <= 1'b0;
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= start_val;
                        stop_reg <= stop_val;
                        busy     <= 1'b1;
                        state    <= COUNT;
                    end
                end
                COUNT: begin
                    // hold freezes everything, including terminal-count detection
                    if (!hold) begin
                        if (count == stop_reg) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            count <= count_inc;
                            wrap  <= carry[WIDTH];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_increment_counter.sv
// Directed + exhaustive bench for increment_counter using a per-cycle
// scoreboard of expected outputs from a behavioural model.

module tb_increment_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] start_val = '0;
    logic [2:0] stop_val = '0;
    logic       hold = 1'b0;
    logic [2:0] count;
    logic       busy;
    logic       done;
    logic       wrap;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [2:0] count;
        logic       busy;
        logic       done;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];

    // model state: 0 idle, 1 counting, 2 done
    int         ms = 0;
    int         mc = 0;
    int         mstop = 0;
    logic       mb = 1'b0;
    logic       md = 1'b0;
    logic       mw = 1'b0;

    always #5 clk = ~clk;

    increment_counter #(.WIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_val (start_val),
        .stop_val  (stop_val),
        .hold      (hold),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    task automatic check(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model(input logic r, input logic s, input int sv, input int pv, input logic h);
        md = 1'b0;
        mw = 1'b0;
        if (r) begin
            ms = 0; mc = 0; mstop = 0; mb = 1'b0;
        end else if (ms == 0) begin
            if (s) begin
                mc = sv; mstop = pv; ms = 1; mb = 1'b1;
            end
        end else if (ms == 1) begin
            if (!h) begin
                if (mc == mstop) begin
                    ms = 2; mb = 1'b0; md = 1'b1;
                end else begin
                    mw = (mc == 7);
                    mc = (mc + 1) % 8;
                end
            end
        end else begin
            ms = 0;
        end
    endtask

    // drive one cycle, push model expectation, then compare after the edge
    task automatic step(input logic r, input logic s, input int sv, input int pv, input logic h);
        exp_t e;
        rst = r; start = s; start_val = 3'(sv); stop_val = 3'(pv); hold = h;
        model(r, s, sv, pv, h);
        e.count = 3'(mc); e.busy = mb; e.done = md; e.wrap = mw;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("count", int'(count), int'(e.count));
            check("busy",  int'(busy),  int'(e.busy));
            check("done",  int'(done),  int'(e.done));
            check("wrap",  int'(wrap),  int'(e.wrap));
        end
    endtask

    // start a run and check done arrives N+1+H edges after the start edge
    task automatic run(input int sv, input int pv, input int hold_from, input int hold_len,
                       input int restart_at);
        int seen = -1;
        int n = (pv - sv + 8) % 8;
        step(1'b0, 1'b1, sv, pv, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, (k == restart_at), (sv + 3) % 8, (pv + 5) % 8,
                 (k >= hold_from) && (k < hold_from + hold_len));
            if (done === 1'b1) begin
                seen = k;
                break;
            end
        end
        check("done_edge", seen, n + 1 + hold_len);
        step(1'b0, 1'b1, 0, 0, 1'b0);
    endtask

    initial begin
        // reset and idle
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 0, 1'b0);

        // plain, wrapping and zero-length runs
        run(2, 5, 100, 0, 0);
        run(6, 1, 100, 0, 0);
        run(4, 4, 100, 0, 0);

        // hold two cycles at count=3, plus an ignored start pulse mid-run
        run(0, 7, 4, 2, 7);

        // reset mid-run at count=4
        step(1'b0, 1'b1, 0, 7, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
        check("mid_count_is_4", int'(count), 4);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b0);

        // exhaustive start/stop pairs
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                run(a, b, 100, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
